// File: rtl/vector_write_unit.sv
// vector_write_unit: store stage of the vector datapath.
// It captures a full vector, or only element 0 for a scalar write, and writes
// one word per cycle through a single BRAM write port. While beats are being
// written, WriterBusy holds the fetch unit off.
module vector_write_unit #(
  parameter int NoOfElem = 16,
  parameter int memDepth = 12,
  parameter int wordSize = 32
) (
  input  logic                               clk,
  input  logic                               RESET,
  input  logic                               start,
  input  logic                               ins,
  input  logic [memDepth-1:0]                writeAddr,
  input  logic [NoOfElem-1:0][wordSize-1:0]  dataIn,
  output logic [memDepth-1:0]                addrOut,
  output logic [wordSize-1:0]                dataOut,
  output logic                               MEMenable,
  output logic                               MEMwe,
  output logic                               WriterBusy,
  output logic                               ready,
  output logic                               done
);

  localparam int IW = $clog2(NoOfElem);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]                        state;
  logic [NoOfElem-1:0][wordSize-1:0] shadow;
  logic [memDepth-1:0]               base;
  logic [IW-1:0]                     idx;
  logic                              mode;

  logic [IW-1:0] idx_next;
  logic          last_beat;

  // idx is the beat currently on the port; decide whether it is the final one
  always_comb begin
    idx_next  = idx + IW'(1);
    last_beat = mode ? (idx == '0) : (idx == IW'(NoOfElem - 1));
  end

  // Outputs are registered, so the beat for idx is loaded one edge ahead,
  // at the edge that makes idx current.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      shadow     <= '0;
      base       <= '0;
      idx        <= '0;
      mode       <= 1'b0;
      addrOut    <= '0;
      dataOut    <= '0;
      MEMenable  <= 1'b0;
      MEMwe      <= 1'b0;
      WriterBusy <= 1'b0;
      ready      <= 1'b1;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shadow     <= dataIn;
            base       <= writeAddr;
            mode       <= ins;
            idx        <= '0;
            addrOut    <= writeAddr;
            dataOut    <= dataIn[0];
            MEMenable  <= 1'b1;
            MEMwe      <= 1'b1;
            WriterBusy <= 1'b1;
            ready      <= 1'b0;
            state      <= WRITE;
          end
        end
        WRITE: begin
          if (last_beat) begin
            MEMenable  <= 1'b0;
            MEMwe      <= 1'b0;
            WriterBusy <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            idx     <= idx_next;
            addrOut <= base + memDepth'(idx_next);
            dataOut <= shadow[idx_next];
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          MEMenable  <= 1'b0;
          MEMwe      <= 1'b0;
          WriterBusy <= 1'b0;
          done       <= 1'b0;
          ready      <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_write_unit.sv
// Testbench for vector_write_unit. A reference model derived from the beat
// timing rules computes the expected port activity for every cycle.
module tb_vector_write_unit;
  localparam int N = 16;
  localparam int D = 12;
  localparam int W = 32;

  logic                 clk = 1'b0;
  logic                 RESET = 1'b0;
  logic                 start = 1'b0;
  logic                 ins = 1'b0;
  logic [D-1:0]         writeAddr = '0;
  logic [N-1:0][W-1:0]  dataIn = '0;
  logic [D-1:0]         addrOut;
  logic [W-1:0]         dataOut;
  logic                 MEMenable, MEMwe, WriterBusy, ready, done;

  int total = 0;
  int bad = 0;

  vector_write_unit #(.NoOfElem(N), .memDepth(D), .wordSize(W)) dut (
    .clk(clk), .RESET(RESET), .start(start), .ins(ins),
    .writeAddr(writeAddr), .dataIn(dataIn),
    .addrOut(addrOut), .dataOut(dataOut), .MEMenable(MEMenable),
    .MEMwe(MEMwe), .WriterBusy(WriterBusy), .ready(ready), .done(done)
  );

  always #5 clk = ~clk;

  // Status word order: {MEMenable, MEMwe, WriterBusy, done, ready}
  localparam logic [4:0] ST_IDLE  = 5'b00001;
  localparam logic [4:0] ST_BEAT  = 5'b11100;
  localparam logic [4:0] ST_DONE  = 5'b00010;
  localparam logic [4:0] ST_RESET = 5'b00001;

  task automatic randomize_inputs();
    writeAddr = D'($urandom);
    ins = 1'($urandom);
    for (int k = 0; k < N; k++) dataIn[k] = $urandom;
  endtask

  // Drive one request at the current negedge and follow it to ready. The
  // expected values come from the model's own copy of the request. Inputs are
  // scrambled every cycle after capture. With disturb set, start is pulsed
  // again in cycle T+5.
  task automatic do_write(input string name, input logic sc, input logic [D-1:0] a,
                          input logic [N-1:0][W-1:0] d, input bit disturb);
    int beats;
    logic [4:0] exp_st;
    logic [D-1:0] ea;
    beats = sc ? 1 : N;
    start = 1'b1; ins = sc; writeAddr = a; dataIn = d;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int j = 1; j <= beats + 2; j++) begin
      if (j <= beats)          exp_st = ST_BEAT;
      else if (j == beats + 1) exp_st = ST_DONE;
      else                     exp_st = ST_IDLE;
      if ({MEMenable, MEMwe, WriterBusy, done, ready} !== exp_st) begin
        bad++;
        $display("FAIL %s status cyc T+%0d got %b exp %b", name, j,
                 {MEMenable, MEMwe, WriterBusy, done, ready}, exp_st);
      end
      total++;
      if (j <= beats) begin
        ea = a + D'(j - 1);
        if (addrOut !== ea) begin
          bad++;
          $display("FAIL %s addr beat %0d got %h exp %h", name, j - 1, addrOut, ea);
        end
        total++;
        if (dataOut !== d[j-1]) begin
          bad++;
          $display("FAIL %s data beat %0d got %h exp %h", name, j - 1, dataOut, d[j-1]);
        end
        total++;
      end
      if (j < beats + 2) begin
        randomize_inputs();
        start = (disturb && j == 5) ? 1'b1 : 1'b0;
        @(negedge clk);
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    for (int c = 0; c < 4; c++) begin
      start = (c == 1);
      @(negedge clk);
      if ({MEMenable, MEMwe, WriterBusy, done, ready} !== ST_RESET ||
          addrOut !== '0 || dataOut !== '0) begin
        bad++;
        $display("FAIL reset_hold cyc %0d status %b addr %h data %h exp status %b zeros",
                 c, {MEMenable, MEMwe, WriterBusy, done, ready}, addrOut, dataOut, ST_RESET);
      end
      total++;
    end
    start = 1'b0;
    RESET = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if ({MEMenable, MEMwe, WriterBusy, done, ready} !== ST_IDLE) begin
        bad++;
        $display("FAIL reset_release cyc %0d got %b exp %b", c,
                 {MEMenable, MEMwe, WriterBusy, done, ready}, ST_IDLE);
      end
      total++;
    end
  endtask

  task automatic test_vector();
    logic [N-1:0][W-1:0] d;
    for (int k = 0; k < N; k++) d[k] = 32'hA000_0000 + W'(k);
    do_write("vector", 1'b0, 12'h100, d, 1'b0);
  endtask

  task automatic test_wrap();
    logic [N-1:0][W-1:0] d;
    for (int k = 0; k < N; k++) d[k] = $urandom;
    do_write("wrap", 1'b0, 12'hFFA, d, 1'b0);
  endtask

  task automatic test_scalar();
    logic [N-1:0][W-1:0] d;
    for (int k = 0; k < N; k++) d[k] = $urandom;
    d[0] = 32'hDEADBEEF;
    do_write("scalar", 1'b1, 12'h020, d, 1'b0);
  endtask

  task automatic test_ignored_start();
    logic [N-1:0][W-1:0] d;
    for (int k = 0; k < N; k++) d[k] = $urandom;
    do_write("ignored_start", 1'b0, 12'h3C0, d, 1'b1);
  endtask

  task automatic test_reset_midop();
    logic [N-1:0][W-1:0] d;
    logic [D-1:0] a;
    a = 12'h480;
    for (int k = 0; k < N; k++) d[k] = $urandom;
    start = 1'b1; ins = 1'b0; writeAddr = a; dataIn = d;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      if (MEMwe !== 1'b1 || addrOut !== a + D'(j - 1) || dataOut !== d[j-1]) begin
        bad++;
        $display("FAIL midop_beat %0d we %b addr %h data %h exp we 1 addr %h data %h",
                 j - 1, MEMwe, addrOut, dataOut, a + D'(j - 1), d[j-1]);
      end
      total++;
      if (j < 8) @(negedge clk);
    end
    #1 RESET = 1'b0;
    #1;
    if ({MEMenable, MEMwe, WriterBusy, done, ready} !== ST_RESET) begin
      bad++;
      $display("FAIL midop_async got %b exp %b",
               {MEMenable, MEMwe, WriterBusy, done, ready}, ST_RESET);
    end
    total++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (MEMwe !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL midop_hold cyc %0d we %b done %b exp 0 0", c, MEMwe, done);
      end
      total++;
    end
    RESET = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N; k++) d[k] = $urandom;
    do_write("after_reset", 1'b0, 12'h7F8, d, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [N-1:0][W-1:0] d;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < N; k++) d[k] = $urandom;
      do_write("back_to_back", (r == 1 || r == 2), D'($urandom), d, 1'b0);
    end
  endtask

  task automatic test_random();
    logic [N-1:0][W-1:0] d;
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < N; k++) d[k] = $urandom;
      do_write("random", 1'($urandom), D'($urandom), d, 1'($urandom));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_vector();
    test_wrap();
    test_scalar();
    @(negedge clk);
    test_ignored_start();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
